reg_write_arbiter: RTL and testbench

REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

---
 rtl/reg_arb_pkg.sv | 18 +
 rtl/reg_write_arbiter_rr_pick.sv | 29 ++
 rtl/reg_write_arbiter.sv | 127 ++++++++++++
 tb/tb_reg_write_arbiter.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/reg_arb_pkg.sv
// Shared types and constants for the register write arbiter.
package reg_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    HOLD  = 2'd2
  } arb_state_e;

  localparam int unsigned WR_CNT_W   = 16;
  localparam int unsigned HOLD_CNT_W = 4;

  // Write counter increment that sticks at all-ones.
  function automatic logic [WR_CNT_W-1:0] sat_inc(input logic [WR_CNT_W-1:0] v);
    return (&v) ? v : v + WR_CNT_W'(1);
  endfunction

endpackage

// File: rtl/reg_write_arbiter_rr_pick.sv
// Round-robin winner search: first set req bit above last_idx, wrapping.
module rr_pick #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last_idx,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Each requester's distance from last_idx; the smallest set distance wins.
  always_comb begin
    int unsigned off;
    int unsigned best_off;
    off      = 0;
    best_off = N_REQ;
    idx      = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      off = (32'(i) + N_REQ - 32'(1) - 32'(last_idx)) % N_REQ;
      if (req[i] && (off < best_off)) begin
        best_off = off;
        idx      = IDX_W'(i);
      end
    end
    any = |req;
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter granting one requester at a time write access to a
// shared register, with a programmable idle hold after every write.
module reg_write_arbiter
  import reg_arb_pkg::*;
#(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned HOLD_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] wdata,
  output logic [N_REQ-1:0]       gnt,
  output logic [WIDTH-1:0]       Q,
  output logic                   busy,
  output logic [WR_CNT_W-1:0]    wr_count
);

  localparam int unsigned IDX_W = $clog2(N_REQ);
  localparam logic [HOLD_CNT_W-1:0] HOLD_LD = HOLD_CNT_W'(HOLD_CYCLES);
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N_REQ - 1);

  arb_state_e            state_q, state_d;
  logic [IDX_W-1:0]      last_idx_q, last_idx_d;
  logic [IDX_W-1:0]      win_q, win_d;
  logic [HOLD_CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [N_REQ-1:0]      gnt_q, gnt_d;
  logic [WIDTH-1:0]      q_q, q_d;
  logic                  busy_q, busy_d;
  logic [WR_CNT_W-1:0]   wr_count_q, wr_count_d;

  logic [IDX_W-1:0]      pick_idx;
  logic                  pick_any;
  logic [WIDTH-1:0]      wsel;

  rr_pick #(
    .N_REQ(N_REQ),
    .IDX_W(IDX_W)
  ) u_rr_pick (
    .req     (req),
    .last_idx(last_idx_q),
    .idx     (pick_idx),
    .any     (pick_any)
  );

  // Data of the latched winner, sampled live at the edge ending GRANT.
  always_comb begin
    wsel = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (win_q == IDX_W'(i)) wsel = wdata[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    state_d    = state_q;
    last_idx_d = last_idx_q;
    win_d      = win_q;
    hold_cnt_d = hold_cnt_q;
    q_d        = q_q;
    wr_count_d = wr_count_q;
    gnt_d      = '0;

    case (state_q)
      IDLE: begin
        if (pick_any) begin
          win_d   = pick_idx;
          state_d = GRANT;
        end
      end
      GRANT: begin
        q_d        = wsel;
        wr_count_d = sat_inc(wr_count_q);
        last_idx_d = win_q;
        if (HOLD_LD != '0) begin
          state_d    = HOLD;
          hold_cnt_d = HOLD_LD;
        end else begin
          state_d = IDLE;
        end
      end
      HOLD: begin
        if (hold_cnt_q <= HOLD_CNT_W'(1)) begin
          state_d    = IDLE;
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q - HOLD_CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Grant and busy are decoded from the next state so they leave the flops aligned.
    for (int i = 0; i < int'(N_REQ); i++) begin
      gnt_d[i] = (state_d == GRANT) && (win_d == IDX_W'(i));
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      last_idx_q <= LAST_RST;
      win_q      <= '0;
      hold_cnt_q <= '0;
      gnt_q      <= '0;
      q_q        <= '0;
      busy_q     <= 1'b0;
      wr_count_q <= '0;
    end else begin
      state_q    <= state_d;
      last_idx_q <= last_idx_d;
      win_q      <= win_d;
      hold_cnt_q <= hold_cnt_d;
      gnt_q      <= gnt_d;
      q_q        <= q_d;
      busy_q     <= busy_d;
      wr_count_q <= wr_count_d;
    end
  end

  assign gnt      = gnt_q;
  assign Q        = q_q;
  assign busy     = busy_q;
  assign wr_count = wr_count_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Bench for reg_write_arbiter: directed scenarios plus random traffic
// against a cycle-level model of the arbitration rules.
module tb_reg_write_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  gnt;
  logic [7:0]  q;
  logic        busy;
  logic [15:0] wr_count;

  logic [3:0]  req0 = '0;
  logic [31:0] wdata0 = '0;
  logic [3:0]  gnt0;
  logic [7:0]  q0;
  logic        busy0;
  logic [15:0] wr_count0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  reg_write_arbiter #(.N_REQ(4), .WIDTH(8), .HOLD_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .wdata(wdata),
    .gnt(gnt), .Q(q), .busy(busy), .wr_count(wr_count)
  );

  reg_write_arbiter #(.N_REQ(4), .WIDTH(8), .HOLD_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req(req0), .wdata(wdata0),
    .gnt(gnt0), .Q(q0), .busy(busy0), .wr_count(wr_count0)
  );

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req = '0; req0 = '0; wdata = '0; wdata0 = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (gnt !== 4'b0000) begin n_err++; $display("FAIL reset_gnt got=%b want=0000", gnt); end
    n_cmp++; if (q !== 8'h00) begin n_err++; $display("FAIL reset_q got=%h want=00", q); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b want=0", busy); end
    n_cmp++; if (wr_count !== 16'h0000) begin n_err++; $display("FAIL reset_wr_count got=%h want=0000", wr_count); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    do_reset();
    req = 4'b0001; wdata[7:0] = 8'hA5;
    @(negedge clk);
    n_cmp++; if (gnt !== 4'b0001) begin n_err++; $display("FAIL single_gnt got=%b want=0001", gnt); end
    n_cmp++; if (q !== 8'h00) begin n_err++; $display("FAIL single_q_early got=%h want=00", q); end
    req = '0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      n_cmp++; if (busy !== (c < 3)) begin n_err++; $display("FAIL single_busy c=%0d got=%b want=%b", c, busy, (c < 3)); end
      n_cmp++; if (gnt !== 4'b0000) begin n_err++; $display("FAIL single_gnt_off c=%0d got=%b want=0000", c, gnt); end
      n_cmp++; if (q !== 8'hA5) begin n_err++; $display("FAIL single_q c=%0d got=%h want=a5", c, q); end
    end
    n_cmp++; if (wr_count !== 16'd1) begin n_err++; $display("FAIL single_wr_count got=%0d want=1", wr_count); end
  endtask

  task automatic test_round_robin();
    logic [3:0] eg;
    do_reset();
    req = 4'b1111; wdata = 32'h13121110;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      eg = (c % 4 == 0) ? (4'b0001 << ((c / 4) % 4)) : 4'b0000;
      n_cmp++; if (gnt !== eg) begin n_err++; $display("FAIL rr_gnt c=%0d got=%b want=%b", c, gnt, eg); end
      if (c % 4 == 1) begin
        n_cmp++; if (q !== 8'(8'h10 + (c / 4) % 4)) begin n_err++; $display("FAIL rr_q c=%0d got=%h want=%h", c, q, 8'(8'h10 + (c / 4) % 4)); end
      end
    end
    req = '0;
  endtask

  task automatic test_hold0();
    logic [3:0] eg;
    do_reset();
    req0 = 4'b0101; wdata0 = 32'h04030201;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      eg = (c % 2 == 0) ? (((c / 2) % 2 == 0) ? 4'b0001 : 4'b0100) : 4'b0000;
      n_cmp++; if (gnt0 !== eg) begin n_err++; $display("FAIL hold0_gnt c=%0d got=%b want=%b", c, gnt0, eg); end
      if (c % 2 == 1) begin
        n_cmp++; if (q0 !== (((c / 2) % 2 == 0) ? 8'h01 : 8'h03)) begin n_err++; $display("FAIL hold0_q c=%0d got=%h", c, q0); end
      end
    end
    req0 = '0;
  endtask

  task automatic test_ignore_hold();
    do_reset();
    req = 4'b0001; wdata = 32'h00007755;
    @(negedge clk);
    n_cmp++; if (gnt !== 4'b0001) begin n_err++; $display("FAIL ign_gnt0 got=%b want=0001", gnt); end
    req = '0;
    for (int c = 1; c < 8; c++) begin
      @(negedge clk);
      n_cmp++; if (gnt !== 4'b0000) begin n_err++; $display("FAIL ign_gnt c=%0d got=%b want=0000", c, gnt); end
      n_cmp++; if (q !== 8'h55) begin n_err++; $display("FAIL ign_q c=%0d got=%h want=55", c, q); end
      if (c == 1) req = 4'b0010;
      if (c == 2) req = 4'b0000;
    end
    n_cmp++; if (wr_count !== 16'd1) begin n_err++; $display("FAIL ign_wr_count got=%0d want=1", wr_count); end
  endtask

  task automatic test_drop_after_latch();
    do_reset();
    req = 4'b0100; wdata[23:16] = 8'h11;
    @(negedge clk);
    n_cmp++; if (gnt !== 4'b0100) begin n_err++; $display("FAIL drop_gnt got=%b want=0100", gnt); end
    req = '0; wdata[23:16] = 8'h9B;
    @(negedge clk);
    n_cmp++; if (q !== 8'h9B) begin n_err++; $display("FAIL drop_q got=%h want=9b", q); end
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    req = 4'b0001; wdata = 32'h000000_3C;
    @(negedge clk);
    n_cmp++; if (gnt !== 4'b0001) begin n_err++; $display("FAIL rmg_gnt got=%b want=0001", gnt); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (q !== 8'h00) begin n_err++; $display("FAIL rmg_q got=%h want=00", q); end
    n_cmp++; if (gnt !== 4'b0000) begin n_err++; $display("FAIL rmg_gnt_off got=%b want=0000", gnt); end
    n_cmp++; if (wr_count !== 16'd0) begin n_err++; $display("FAIL rmg_wr got=%0d want=0", wr_count); end
    @(negedge clk);
    rst_n = 1'b1;
    req = 4'b1001;
    n_cmp++; if (q !== 8'h00) begin n_err++; $display("FAIL rmg_q_rel got=%h want=00", q); end
    n_cmp++; if (wr_count !== 16'd0) begin n_err++; $display("FAIL rmg_wr_rel got=%0d want=0", wr_count); end
    @(negedge clk);
    n_cmp++; if (gnt !== 4'b0001) begin n_err++; $display("FAIL rmg_first_gnt got=%b want=0001", gnt); end
    req = '0;
    @(negedge clk);
    n_cmp++; if (q !== 8'h3C) begin n_err++; $display("FAIL rmg_q_after got=%h want=3c", q); end
  endtask

  task automatic test_saturate();
    do_reset();
    dut0.wr_count_q = 16'hFFFE;
    req0 = 4'b0001; wdata0[7:0] = 8'h5A;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 1 || c == 5) begin
        n_cmp++; if (wr_count0 !== 16'hFFFF) begin n_err++; $display("FAIL sat_wr c=%0d got=%h want=ffff", c, wr_count0); end
      end
      if (c == 4) req0 = '0;
    end
  endtask

  function automatic int rr_win(input logic [3:0] r, input int last);
    for (int k = 1; k <= 4; k++) if (r[(last + k) % 4]) return (last + k) % 4;
    return last;
  endfunction

  task automatic test_random();
    int m_last = 3, m_win = 0, m_left = 0;
    bit m_in_grant = 0;
    logic [7:0]  m_q = '0;
    logic [15:0] m_cnt = '0;
    logic [3:0]  m_gnt;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      req = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
      wdata = $urandom;
      if (m_left > 0) begin
        if (m_in_grant) begin
          m_q = wdata[m_win*8 +: 8];
          m_cnt = (m_cnt == 16'hFFFF) ? m_cnt : m_cnt + 16'd1;
          m_last = m_win;
          m_in_grant = 0;
        end
        m_left--;
      end else if (req != 4'b0000) begin
        m_win = rr_win(req, m_last);
        m_in_grant = 1;
        m_left = 3;
      end
      m_gnt = m_in_grant ? (4'b0001 << m_win) : 4'b0000;
      @(negedge clk);
      n_cmp++; if (gnt !== m_gnt) begin n_err++; $display("FAIL rnd_gnt c=%0d got=%b want=%b", c, gnt, m_gnt); end
      n_cmp++; if (q !== m_q) begin n_err++; $display("FAIL rnd_q c=%0d got=%h want=%h", c, q, m_q); end
      n_cmp++; if (busy !== (m_left > 0)) begin n_err++; $display("FAIL rnd_busy c=%0d got=%b want=%b", c, busy, (m_left > 0)); end
      n_cmp++; if (wr_count !== m_cnt) begin n_err++; $display("FAIL rnd_wr c=%0d got=%0d want=%0d", c, wr_count, m_cnt); end
    end
    req = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_single();
    test_round_robin();
    test_hold0();
    test_ignore_hold();
    test_drop_after_latch();
    test_reset_mid_grant();
    test_saturate();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
